// File: rtl/temporal_encoder_pkg.sv
// Shared definitions for the temporal N-gram encoder: default sizes, FSM encoding
// and the width helper used to size the step and fill counters.
package temporal_encoder_pkg;

  localparam int DEFAULT_HV_DIMENSION = 2048;
  localparam int DEFAULT_NGRAM_SIZE   = 3;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    COMPUTE       = 2'd1,
    OUTPUT_STABLE = 2'd2
  } te_state_e;

  function automatic int ceil_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/temporal_encoder.sv
// Temporal N-gram encoder: Y_t = X_t ^ rho(H0) ^ ... ^ rho^(N-1)(H(N-2)), folded one
// history term per cycle. Optional TE_WARMUP_SKIP_EN suppresses outputs until history is full.
module temporal_encoder
  import temporal_encoder_pkg::*;
#(
  parameter int HV_DIMENSION = DEFAULT_HV_DIMENSION,
  parameter int NGRAM_SIZE   = DEFAULT_NGRAM_SIZE
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RI,
  input  logic                    ValidIn_SI,
  output logic                    ReadyOut_SO,
  input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
  input  logic                    Flush_SI,
  output logic                    ValidOut_SO,
  input  logic                    ReadyIn_SI,
  output logic [0:HV_DIMENSION-1] HypervectorOut_DO
);

  // At least one history slot exists so N=1 builds stay well-formed; it is never read then.
  localparam int NUM_HIST = (NGRAM_SIZE > 1) ? NGRAM_SIZE - 1 : 1;
  localparam int CNT_W    = (ceil_log2(NGRAM_SIZE) < 1) ? 1 : ceil_log2(NGRAM_SIZE);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NGRAM_SIZE - 1);

  typedef logic [0:HV_DIMENSION-1] hv_t;

  te_state_e                  state_q, state_d;
  hv_t                        acc_q, acc_d;
  hv_t                        query_q, query_d;
  logic [NUM_HIST-1:0][0:HV_DIMENSION-1] hist_q, hist_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [CNT_W-1:0]           fill_q, fill_d;
  hv_t                        src;

  // Index 0 is the MSB, so rotating toward higher index moves the last bit to the front.
  function automatic hv_t rho(input hv_t v);
    return {v[HV_DIMENSION-1], v[0:HV_DIMENSION-2]};
  endfunction

  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      state_q <= IDLE;
      acc_q   <= '0;
      query_q <= '0;
      hist_q  <= '0;
      cnt_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      query_q <= query_d;
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
    end
  end

  // Horner source: older history first, the captured query on the last step.
  always_comb begin
    src = query_q;
    for (int i = 0; i < NUM_HIST; i++)
      if (int'(cnt_q) == i + 2) src = hist_q[i];
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    query_d = query_q;
    hist_d  = hist_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE: begin
        if (Flush_SI) begin
          hist_d = '0;
          fill_d = '0;
        end
        if (ValidIn_SI) begin
          query_d = HypervectorIn_DI;
          if (NGRAM_SIZE == 1) begin
            acc_d   = HypervectorIn_DI;
            state_d = OUTPUT_STABLE;
          end else begin
            // A same-cycle flush means this input starts a fresh, all-zero history.
            acc_d   = Flush_SI ? '0 : hist_q[NUM_HIST-1];
            cnt_d   = CNT_LOAD;
            state_d = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        acc_d = rho(acc_q) ^ src;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hist_d[0] = query_q;
          for (int i = 1; i < NUM_HIST; i++) hist_d[i] = hist_q[i-1];
          if (fill_q != CNT_LOAD) fill_d = fill_q + CNT_W'(1);
`ifdef TE_WARMUP_SKIP_EN
          state_d = (fill_q < CNT_LOAD) ? IDLE : OUTPUT_STABLE;
`else
          state_d = OUTPUT_STABLE;
`endif
        end
      end
      OUTPUT_STABLE: begin
        if (ReadyIn_SI) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ReadyOut_SO = (state_q == IDLE);
    ValidOut_SO = (state_q == OUTPUT_STABLE);
  end

  assign HypervectorOut_DO = acc_q;

endmodule
